// File: rtl/video_tsline_buf.sv
// Multi-bank TS-overlay pixel line buffer.
// The renderer fills wr_bank while the pixel path drains rd_bank, which always
// sits one bank ahead of wr_bank (modulo BANKS). Every consumed pixel is
// cleared back to TRANSP so the bank is blank once it rotates round to be
// written again. After reset an INIT sweep clears all banks before any traffic
// is accepted.
//
// Strobe semantics: there is no back-pressure. i_we and i_rd_stb are single-
// cycle qualifiers sampled on the rising clock edge; a strobe is acted on in
// the cycle it is high (RUN state) or discarded (INIT state). o_ready is a
// status flag, not a handshake.
module video_tsline_buf #(
  parameter int AW = 9,
  parameter int DW = 8,
  parameter int BANKS = 2,
  parameter logic [DW-1:0] TRANSP = '0,
  localparam int BW = (BANKS > 2) ? $clog2(BANKS) : 1
) (
  input  logic          i_clk,
  input  logic          i_res,
  input  logic          i_line_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd_stb,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  output logic [BW-1:0] o_wr_bank,
  output logic [BW-1:0] o_rd_bank,
  output logic          o_ready,
  output logic [7:0]    o_wr_drop,
  output logic          o_dbg_state
);

  localparam int DEPTH = BANKS * (2 ** AW);
  localparam int CW    = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_LOC  = CW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_init_cnt;
  logic            r_ready;
  logic [7:0]      r_wr_drop;
  logic [BW-1:0]   r_wr_bank;
  logic [BW-1:0]   r_rd_bank;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [BW-1:0]   w_wr_next;
  logic [BW-1:0]   w_rd_next;
  logic [CW-1:0]   w_wr_idx;
  logic [CW-1:0]   w_rd_idx;
  logic            w_init_we;
  logic            w_clr_we;
  logic            w_ren_we;

  // Next bank indices (wrap at BANKS, which need not be a power of two) and
  // flat RAM indices {bank, addr} for the two live ports.
  always_comb begin
    w_wr_next = (r_wr_bank == LAST_BANK) ? '0 : r_wr_bank + BW'(1);
    w_rd_next = (r_rd_bank == LAST_BANK) ? '0 : r_rd_bank + BW'(1);
    w_wr_idx  = (CW'(r_wr_bank) << AW) | CW'(i_waddr);
    w_rd_idx  = (CW'(r_rd_bank) << AW) | CW'(i_raddr);
    w_init_we = (r_state == ST_INIT);
    w_clr_we  = (r_state == ST_RUN) && i_rd_stb;
    w_ren_we  = (r_state == ST_RUN) && i_we && (i_wdata != TRANSP);
  end

  // Control FSM: INIT sweep then terminal RUN with bank rotation and read-out.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
      r_wr_drop  <= '0;
      r_wr_bank  <= '0;
      r_rd_bank  <= BW'(1);
      r_rdata    <= TRANSP;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Renderer writes cannot land yet; count them so the loss is visible.
          if (i_we && (r_wr_drop != 8'hFF)) begin
            r_wr_drop <= r_wr_drop + 8'd1;
          end
          if (r_init_cnt == LAST_LOC) begin
            r_state <= ST_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
          // Pre-clear content is returned; the clear happens in the RAM block.
          if (i_rd_stb) begin
            r_rdata <= r_mem[w_rd_idx];
          end
          // Same-cycle accesses above used the old indices.
          if (i_line_start) begin
            r_wr_bank <= w_wr_next;
            r_rd_bank <= w_rd_next;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Pixel RAM: INIT sweep port, or clear-on-read of rd_bank plus renderer
  // write of wr_bank. The two RUN ports always hit different banks.
  always_ff @(posedge i_clk) begin
    if (w_init_we) begin
      r_mem[r_init_cnt] <= TRANSP;
    end else begin
      if (w_clr_we) begin
        r_mem[w_rd_idx] <= TRANSP;
      end
      if (w_ren_we) begin
        r_mem[w_wr_idx] <= i_wdata;
      end
    end
  end

  assign o_rdata     = r_rdata;
  assign o_wr_bank   = r_wr_bank;
  assign o_rd_bank   = r_rd_bank;
  assign o_ready     = r_ready;
  assign o_wr_drop   = r_wr_drop;
  assign o_dbg_state = (r_state == ST_RUN);

endmodule

// File: tb/tb_video_tsline_buf.sv
// Bench for video_tsline_buf: two instances (2 banks x 512 px, TRANSP=00 and
// 4 banks x 16 px, TRANSP=E5) share one stimulus stream. A line-level model
// tracks both and is compared on every falling edge; directed sections add
// literal expectations.
module tb_video_tsline_buf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       line_start = 1'b0;
  logic       we = 1'b0;
  logic [8:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       rd_stb = 1'b0;
  logic [8:0] raddr = '0;

  logic [7:0] rdata2, rdata4, drop2, drop4;
  logic [0:0] wb2, rb2;
  logic [1:0] wb4, rb4;
  logic       rdy2, rdy4, st2, st4;

  video_tsline_buf #(.AW(9), .DW(8), .BANKS(2), .TRANSP(8'h00)) u_dut2 (
    .i_clk(clk), .i_res(res), .i_line_start(line_start), .i_we(we),
    .i_waddr(waddr), .i_wdata(wdata), .i_rd_stb(rd_stb), .i_raddr(raddr),
    .o_rdata(rdata2), .o_wr_bank(wb2), .o_rd_bank(rb2), .o_ready(rdy2),
    .o_wr_drop(drop2), .o_dbg_state(st2)
  );

  video_tsline_buf #(.AW(4), .DW(8), .BANKS(4), .TRANSP(8'hE5)) u_dut4 (
    .i_clk(clk), .i_res(res), .i_line_start(line_start), .i_we(we),
    .i_waddr(waddr[3:0]), .i_wdata(wdata), .i_rd_stb(rd_stb), .i_raddr(raddr[3:0]),
    .o_rdata(rdata4), .o_wr_bank(wb4), .o_rd_bank(rb4), .o_ready(rdy4),
    .o_wr_drop(drop4), .o_dbg_state(st4)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instance k: BANKS, AW and TRANSP. Time is counted as clock edges since
  // reset release: the first BANKS*2^AW edges are the clear sweep, every later
  // edge is normal operation, and ready shows from edge BANKS*2^AW+1 onwards.
  int         p_banks [2] = '{2, 4};
  int         p_aw    [2] = '{9, 4};
  logic [7:0] p_tr    [2] = '{8'h00, 8'hE5};

  logic [7:0] m_mem  [2][1024];
  int         m_edges[2];
  int         m_wb   [2];
  logic [7:0] m_rd   [2];
  int         m_drop [2];

  function automatic int depth_of(input int k);
    return p_banks[k] << p_aw[k];
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 1024; i++) m_mem[k][i] = p_tr[k];
    m_edges[k] = 0;
    m_wb[k]    = 0;
    m_rd[k]    = p_tr[k];
    m_drop[k]  = 0;
  endtask

  task automatic model_step(input int k);
    int ed, rb, line, wa, ra;
    ed   = m_edges[k] + 1;
    line = 1 << p_aw[k];
    if (ed <= depth_of(k)) begin
      if (we && m_drop[k] < 255) m_drop[k]++;
    end else begin
      rb = (m_wb[k] + 1) % p_banks[k];
      wa = int'(waddr) % line;
      ra = int'(raddr) % line;
      if (rd_stb) begin
        m_rd[k] = m_mem[k][rb * line + ra];
        m_mem[k][rb * line + ra] = p_tr[k];
      end
      if (we && wdata != p_tr[k]) m_mem[k][m_wb[k] * line + wa] = wdata;
      if (line_start) m_wb[k] = (m_wb[k] + 1) % p_banks[k];
    end
    m_edges[k] = (ed > depth_of(k) + 2) ? depth_of(k) + 2 : ed;
  endtask

  always @(posedge clk or posedge res) begin
    if (res) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input int k, input logic [7:0] rd, input logic [31:0] wb,
                     input logic [31:0] rb, input logic rdy, input logic [7:0] drop,
                     input logic st);
    chk($sformatf("rdata%0d", k), 32'(rd), 32'(m_rd[k]));
    chk($sformatf("wr_bank%0d", k), wb, 32'(m_wb[k]));
    chk($sformatf("rd_bank%0d", k), rb, 32'((m_wb[k] + 1) % p_banks[k]));
    chk($sformatf("bank_invariant%0d", k), rb, (wb + 32'd1) % 32'(p_banks[k]));
    chk($sformatf("ready%0d", k), 32'(rdy), 32'(m_edges[k] >= depth_of(k) + 1));
    chk($sformatf("wr_drop%0d", k), 32'(drop), 32'(m_drop[k]));
    chk($sformatf("dbg_state%0d", k), 32'(st), 32'(m_edges[k] >= depth_of(k)));
  endtask

  always @(negedge clk) begin
    cmp(0, rdata2, 32'(wb2), 32'(rb2), rdy2, drop2, st2);
    cmp(1, rdata4, 32'(wb4), 32'(rb4), rdy4, drop4, st4);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    line_start = 1'b0;
    we         = 1'b0;
    rd_stb     = 1'b0;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [7:0] d);
    idle(); we = 1'b1; waddr = a; wdata = d; tick(); idle();
  endtask

  task automatic do_rotate();
    idle(); line_start = 1'b1; tick(); idle();
  endtask

  task automatic do_read(input logic [8:0] a);
    idle(); rd_stb = 1'b1; raddr = a; tick(); idle();
  endtask

  // Wait for both instances to report ready, bounded.
  task automatic wait_ready(output int n2, output int n4);
    int n;
    n = 0; n2 = 0; n4 = 0;
    while (n < 1100 && !(rdy2 && rdy4)) begin
      tick();
      n++;
      if (rdy2 && n2 == 0) n2 = n;
      if (rdy4 && n4 == 0) n4 = n;
    end
    if (!(rdy2 && rdy4)) chk("ready_timeout", {30'd0, rdy2, rdy4}, 32'd3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, n2, n4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata2", 32'(rdata2), 32'h00);
    chk("reset_rdata4", 32'(rdata4), 32'hE5);
    chk("reset_rd_bank4", 32'(rb4), 32'd1);
    res = 1'b0;

    // Clear sweep with renderer writes hammering for the first 600 edges.
    n = 0; n2 = 0; n4 = 0;
    while (n < 1100 && !rdy2) begin
      we    = (n < 600);
      wdata = 8'h55;
      waddr = 9'($urandom_range(0, 511));
      tick();
      n++;
      if (rdy4 && n4 == 0) n4 = n;
      if (rdy2) n2 = n;
    end
    idle();
    chk("ready_latency2", 32'(n2), 32'd1025);
    chk("ready_latency4", 32'(n4), 32'd65);
    chk("wr_drop2_sat", 32'(drop2), 32'd255);
    chk("wr_drop4", 32'(drop4), 32'd64);

    // Freshly swept read bank returns transparent.
    for (int i = 0; i < 8; i++) begin
      do_read(9'($urandom_range(0, 511)));
      chk("post_init_read2", 32'(rdata2), 32'h00);
    end

    // Write, rotate, read twice: data then cleared.
    do_write(9'd10, 8'h3C);
    do_rotate();
    do_read(9'd10);
    chk("read_written2", 32'(rdata2), 32'h3C);
    do_read(9'd10);
    chk("read_cleared2", 32'(rdata2), 32'h00);

    // Transparent write keeps earlier content.
    do_write(9'd5, 8'h21);
    do_write(9'd5, 8'h00);
    do_rotate();
    do_read(9'd5);
    chk("transp_suppressed2", 32'(rdata2), 32'h21);

    // Drain every 4-bank location once so marker checks start clean.
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) do_read(9'(a));
      do_rotate();
    end

    // Markers appear BANKS-1 rotations after they were written.
    for (int l = 0; l < 8; l++) begin
      idle();
      rd_stb = 1'b1; raddr = 9'd0;
      if (l < 4) begin
        we = 1'b1; waddr = 9'd0; wdata = 8'hA0 + 8'(l);
      end
      tick();
      idle();
      if (l >= 3 && l <= 6) chk("marker4", 32'(rdata4), 32'hA0 + 32'(l - 3));
      else chk("marker4_blank", 32'(rdata4), 32'hE5);
      do_rotate();
    end

    // line_start, write and read in the same cycle use the old banks.
    do_write(9'd20, 8'h77);
    do_rotate();
    idle();
    line_start = 1'b1;
    we = 1'b1; waddr = 9'd30; wdata = 8'h99;
    rd_stb = 1'b1; raddr = 9'd20;
    tick();
    idle();
    chk("same_cycle_read2", 32'(rdata2), 32'h77);
    do_read(9'd30);
    chk("same_cycle_write2", 32'(rdata2), 32'h99);

    // Asynchronous reset in the middle of a cycle.
    do_write(9'd40, 8'h5A);
    @(posedge clk);
    #3 res = 1'b1;
    #1;
    chk("midreset_rdata2", 32'(rdata2), 32'h00);
    chk("midreset_wr_bank2", 32'(wb2), 32'd0);
    chk("midreset_rd_bank2", 32'(rb2), 32'd1);
    chk("midreset_ready2", 32'(rdy2), 32'd0);
    chk("midreset_rd_bank4", 32'(rb4), 32'd1);
    @(posedge clk);
    #1 res = 1'b0;
    wait_ready(n2, n4);

    // Every location reads transparent after the new sweep.
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 512; a++) begin
        do_read(9'(a));
        chk("reinit_read2", 32'(rdata2), 32'h00);
      end
      do_rotate();
    end
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        do_read(9'(a));
        chk("reinit_read4", 32'(rdata4), 32'hE5);
      end
      do_rotate();
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      line_start = ($urandom_range(0, 15) == 0);
      we         = 1'($urandom_range(0, 1));
      waddr      = 9'($urandom_range(0, 511));
      case ($urandom_range(0, 3))
        0:       wdata = 8'h00;
        1:       wdata = 8'hE5;
        default: wdata = 8'($urandom_range(0, 255));
      endcase
      rd_stb = 1'($urandom_range(0, 1));
      raddr  = 9'($urandom_range(0, 511));
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_tsline_buf.md
Name: video_tsline_buf

Overview:
- Parametrised N-bank pixel line buffer for the tile/sprite (TS) overlay. It generalises the fixed pair of ping-pong TS-line RAMs.
- The TS renderer writes the upcoming line(s) while the pixel path reads the oldest bank. Each read location is cleared to the transparent value as it is consumed.
- Adds rotation over BANKS ≥ 2 lines, a transparent-write filter, and a post-reset clear sweep with a ready flag.
- Sits between video_ts_render (write side) and video_render (tsdata_in, read side).

Parameters:
AW, 9, address width; each bank holds 2^AW pixels
DW, 8, pixel width in bits
BANKS, 2, number of line banks; legal range 2..8
TRANSP, 0, DW-bit transparent/cleared pixel value

Ports:
clk  in  1  video clock
res  in  1  asynchronous active-high reset
line_start  in  1  one-cycle pulse; rotates banks
we  in  1  renderer write strobe
waddr  in  AW  renderer write address (pixel x)
wdata  in  DW  renderer pixel
rd_stb  in  1  pixel-path read strobe (c3-rate)
raddr  in  AW  read address
rdata  out  DW  registered read pixel
wr_bank  out  clog2(BANKS) (min 1)  bank currently written
rd_bank  out  clog2(BANKS) (min 1)  bank currently read/cleared
ready  out  1  init sweep finished
wr_drop  out  8  saturating count of writes discarded while not ready

Behaviour:
- Reset (asynchronous), all outputs: rdata=TRANSP, wr_bank=0, rd_bank=1, ready=0, wr_drop=0. The FSM enters INIT with sweep counter=0.
- FSM states: INIT and RUN.
  - INIT writes TRANSP to one location per clk, sweeping bank 0 addr 0 through bank BANKS-1 addr 2^AW-1. This takes BANKS·2^AW cycles.
  - After the final location, the FSM moves to RUN and ready=1 on the following cycle.
  - RUN is terminal until res.
- In INIT:
  - line_start is ignored and rd_stb is ignored; rdata is held at TRANSP.
  - Each cycle with we=1 increments wr_drop, saturating at 255; the write is discarded.
- Bank rotation (RUN only): on line_start, wr_bank←(wr_bank+1) mod BANKS and rd_bank←(rd_bank+1) mod BANKS. The invariant rd_bank==(wr_bank+1) mod BANKS always holds.
- Events in the same cycle as line_start use the pre-rotation bank indices. The new indices apply from the next cycle.
- Write (RUN):
  - When we=1 and wdata≠TRANSP, mem[wr_bank][waddr]←wdata at the clock edge.
  - wdata==TRANSP produces no write. Existing content is kept (transparent overlay pixel).
  - Writes never target rd_bank.
- Read/clear (RUN): when rd_stb=1, at the clock edge:
  - rdata←mem[rd_bank][raddr], the pre-clear content.
  - mem[rd_bank][raddr]←TRANSP, in the same cycle.
  - Latency is 1 clk. rdata holds its value while rd_stb=0.
- Read-during-clear of the same location returns the old data. There is no write/read collision because the write bank and read bank always differ.
- Address wrap: addresses are AW bits wide, so no out-of-range access exists.
- BANKS>2: a line written in bank k is read after BANKS-1 line_start pulses. Intermediate banks hold completed lines untouched.
- Reset asserted mid-operation aborts immediately. Contents are re-cleared by a new INIT; no partial state survives.
- Implementation:
  - One simple dual-port RAM per bank, or one RAM of BANKS·2^AW words addressed {bank, addr}.
  - The write port of the read bank is muxed to the clear path. The write port of all other banks is muxed to the renderer or to INIT.

Test Plan:
1. Deassert res with BANKS=2, AW=9; count cycles → ready rises exactly 1024+1 cycles after res falls. Pulse we throughout with wdata=0x55 → wr_drop=min(writes,255) and every read after ready returns 0.
2. After ready: write addr 10 = 0x3C, pulse line_start, read addr 10 twice → first read returns 0x3C, second read returns 0x00 (cleared).
3. Write addr 5 = 0x21, then write addr 5 with wdata=TRANSP, rotate, read addr 5 → returns 0x21 (transparent write suppressed).
4. BANKS=4: write line markers 0xA0..0xA3 at addr 0 across four lines (line_start between each), keep rotating and reading → each marker returns exactly BANKS-1=3 rotations after it was written. The wr_bank/rd_bank invariant holds on every cycle.
5. Assert line_start, we and rd_stb in the same cycle → the write lands in the old wr_bank and the read comes from the old rd_bank. The indices change only on the next cycle.
6. Assert res while in RUN with data present → outputs immediately return to reset values. After the new INIT, every location reads TRANSP.
